// File: rtl/char_rom_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// char_rom_arb_pkg
// Shared types and constants for the two-requester character ROM arbiter.
//   arb_state_e        : arbiter FSM states (IDLE, BURST)
//   RD_LATENCY_NO_OREG : ROM read latency without the output register
//   RD_LATENCY_OREG    : ROM read latency with the output register enabled
//   rsp_tag_t          : per-beat tag carried alongside the ROM read
// -----------------------------------------------------------------------------
package char_rom_arb_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      BURST = 1'b1
   } arb_state_e;

   localparam int RD_LATENCY_NO_OREG = 1;
   localparam int RD_LATENCY_OREG    = 2;

   typedef struct packed {
      logic valid;
      logic owner;
      logic last;
   } rsp_tag_t;

endpackage

// File: rtl/char_rom_arbiter_if.sv
// -----------------------------------------------------------------------------
// char_rom_arbiter_if
// Bundles the request, response, ROM and status signals of the arbiter.
//   req0_* / req1_* : burst requests (valid/addr/len in, ready out)
//   rsp0_* / rsp1_* : read responses (valid/data/last)
//   rom_*           : ROM address, output-register enable and read data
//   busy            : arbiter activity flag
// The slave modport is the arbiter's view, the master modport the
// environment's view (requesters plus ROM).
// -----------------------------------------------------------------------------
interface char_rom_arbiter_if
   import char_rom_arb_pkg::*;
#(
   parameter int ADDR_WIDTH = 10,
   parameter int DATA_WIDTH = 32
);

   logic                  req0_valid;
   logic                  req0_ready;
   logic [ADDR_WIDTH-1:0] req0_addr;
   logic [3:0]            req0_len;
   logic                  req1_valid;
   logic                  req1_ready;
   logic [ADDR_WIDTH-1:0] req1_addr;
   logic [3:0]            req1_len;

   logic                  rsp0_valid;
   logic [DATA_WIDTH-1:0] rsp0_data;
   logic                  rsp0_last;
   logic                  rsp1_valid;
   logic [DATA_WIDTH-1:0] rsp1_data;
   logic                  rsp1_last;

   logic [ADDR_WIDTH-1:0] rom_addr;
   logic                  rom_rd_oce;
   logic [DATA_WIDTH-1:0] rom_rd_data;

   logic                  busy;

   modport slave (
      input  req0_valid, req0_addr, req0_len,
      input  req1_valid, req1_addr, req1_len,
      input  rom_rd_data,
      output req0_ready, req1_ready,
      output rsp0_valid, rsp0_data, rsp0_last,
      output rsp1_valid, rsp1_data, rsp1_last,
      output rom_addr, rom_rd_oce, busy
   );

   modport master (
      output req0_valid, req0_addr, req0_len,
      output req1_valid, req1_addr, req1_len,
      output rom_rd_data,
      input  req0_ready, req1_ready,
      input  rsp0_valid, rsp0_data, rsp0_last,
      input  rsp1_valid, rsp1_data, rsp1_last,
      input  rom_addr, rom_rd_oce, busy
   );

endinterface

// File: rtl/char_rom_rsp_pipe.sv
// -----------------------------------------------------------------------------
// char_rom_rsp_pipe
// Delays the per-beat {valid, owner, last} tag by RD_LATENCY cycles so it
// lines up with the data leaving the ROM.
//   clk, rst    : clock and synchronous active-high reset
//   tag_in      : tag of the beat currently on rom_addr
//   tag_out     : tag of the beat whose data is on rom_rd_data now
//   first_valid : a beat sits in the first stage (drives the ROM oce)
//   any_valid   : at least one beat is still in flight
// -----------------------------------------------------------------------------
module char_rom_rsp_pipe
   import char_rom_arb_pkg::*;
#(
   parameter int RD_LATENCY = RD_LATENCY_NO_OREG
) (
   input  logic     clk,
   input  logic     rst,
   input  rsp_tag_t tag_in,
   output rsp_tag_t tag_out,
   output logic     first_valid,
   output logic     any_valid
);

   rsp_tag_t stage_q [RD_LATENCY];
   rsp_tag_t stage_d [RD_LATENCY];

   // Each stage takes the one before it; stage 0 captures the issued beat.
   always_comb begin
      stage_d[0] = tag_in;
      for (int i = 1; i < RD_LATENCY; i++) begin
         stage_d[i] = stage_q[i-1];
      end
   end

   // Reset flushes every stage so aborted beats never produce a response.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < RD_LATENCY; i++) begin
            stage_q[i] <= '0;
         end
      end else begin
         for (int i = 0; i < RD_LATENCY; i++) begin
            stage_q[i] <= stage_d[i];
         end
      end
   end

   // OR of all stage valids tells the top whether anything is in flight.
   always_comb begin
      any_valid = 1'b0;
      for (int i = 0; i < RD_LATENCY; i++) begin
         any_valid = any_valid | stage_q[i].valid;
      end
   end

   assign tag_out     = stage_q[RD_LATENCY-1];
   assign first_valid = stage_q[0].valid;

endmodule

// File: rtl/char_rom_arbiter.sv
// -----------------------------------------------------------------------------
// char_rom_arbiter
// Round-robin arbiter giving two requesters burst access to a character ROM.
//   clk, rst : clock and synchronous active-high reset
//   bus      : char_rom_arbiter_if slave modport (requests, responses, ROM
//              port and busy flag)
// A granted burst of len+1 beats is issued one address per cycle starting the
// cycle after acceptance; responses return RD_LATENCY cycles later.
// -----------------------------------------------------------------------------
module char_rom_arbiter
   import char_rom_arb_pkg::*;
#(
   parameter int ADDR_WIDTH = 10,
   parameter int DATA_WIDTH = 32,
   parameter int RD_LATENCY = RD_LATENCY_NO_OREG
) (
   input  logic               clk,
   input  logic               rst,
   char_rom_arbiter_if.slave  bus
);

   arb_state_e            state_q, state_d;
   logic                  ptr_q, ptr_d;
   logic                  owner_q, owner_d;
   logic                  last_q, last_d;
   logic                  issue_q, issue_d;
   logic [3:0]            len_q, len_d;
   logic [3:0]            cnt_q, cnt_d;
   logic [ADDR_WIDTH-1:0] rom_addr_q, rom_addr_d;

   logic                  grant_valid;
   logic                  grant_sel;
   rsp_tag_t              tag_in, tag_out;
   logic                  first_valid, any_valid;

   // Grant only from IDLE; with both requesting, the pointer decides.
   // Reset masks the grant so ready stays low while rst is held.
   always_comb begin
      grant_valid = !rst && (state_q == IDLE) && (bus.req0_valid || bus.req1_valid);
      if (bus.req0_valid && bus.req1_valid) begin
         grant_sel = ptr_q;
      end else begin
         grant_sel = bus.req1_valid;
      end
   end

   // Next-state logic: acceptance loads the first beat onto rom_addr for the
   // following cycle; in BURST each cycle advances one beat until the final
   // beat is on the bus, after which the FSM drops back to IDLE.
   always_comb begin
      state_d    = state_q;
      ptr_d      = ptr_q;
      owner_d    = owner_q;
      len_d      = len_q;
      cnt_d      = cnt_q;
      rom_addr_d = rom_addr_q;
      issue_d    = 1'b0;
      last_d     = 1'b0;
      case (state_q)
         IDLE: begin
            if (grant_valid) begin
               state_d    = BURST;
               ptr_d      = ~grant_sel;
               owner_d    = grant_sel;
               len_d      = grant_sel ? bus.req1_len  : bus.req0_len;
               rom_addr_d = grant_sel ? bus.req1_addr : bus.req0_addr;
               cnt_d      = 4'd0;
               issue_d    = 1'b1;
               last_d     = (len_d == 4'd0);
            end
         end
         BURST: begin
            if (cnt_q == len_q) begin
               state_d = IDLE;
            end else begin
               cnt_d      = cnt_q + 4'd1;
               rom_addr_d = rom_addr_q + ADDR_WIDTH'(1);
               issue_d    = 1'b1;
               last_d     = (cnt_d == len_q);
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State register; reset aborts any burst and re-arms the pointer to req0.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         ptr_q      <= 1'b0;
         owner_q    <= 1'b0;
         last_q     <= 1'b0;
         issue_q    <= 1'b0;
         len_q      <= 4'd0;
         cnt_q      <= 4'd0;
         rom_addr_q <= '0;
      end else begin
         state_q    <= state_d;
         ptr_q      <= ptr_d;
         owner_q    <= owner_d;
         last_q     <= last_d;
         issue_q    <= issue_d;
         len_q      <= len_d;
         cnt_q      <= cnt_d;
         rom_addr_q <= rom_addr_d;
      end
   end

   // The tag travels with the beat currently on rom_addr.
   always_comb begin
      tag_in       = '0;
      tag_in.valid = issue_q;
      tag_in.owner = owner_q;
      tag_in.last  = last_q;
   end

   char_rom_rsp_pipe #(
      .RD_LATENCY (RD_LATENCY)
   ) u_rsp_pipe (
      .clk         (clk),
      .rst         (rst),
      .tag_in      (tag_in),
      .tag_out     (tag_out),
      .first_valid (first_valid),
      .any_valid   (any_valid)
   );

   // Response steering: ROM data is passed straight to the owner and zeroed
   // otherwise, so idle data lines read as zero.
   always_comb begin
      bus.req0_ready = grant_valid && !grant_sel;
      bus.req1_ready = grant_valid &&  grant_sel;
      bus.rsp0_valid = tag_out.valid && !tag_out.owner;
      bus.rsp1_valid = tag_out.valid &&  tag_out.owner;
      bus.rsp0_last  = bus.rsp0_valid && tag_out.last;
      bus.rsp1_last  = bus.rsp1_valid && tag_out.last;
      bus.rsp0_data  = bus.rsp0_valid ? bus.rom_rd_data : {DATA_WIDTH{1'b0}};
      bus.rsp1_data  = bus.rsp1_valid ? bus.rom_rd_data : {DATA_WIDTH{1'b0}};
      bus.rom_addr   = rom_addr_q;
      bus.rom_rd_oce = (RD_LATENCY == RD_LATENCY_OREG) ? first_valid : 1'b0;
      bus.busy       = (state_q != IDLE) || any_valid;
   end

endmodule

// File: tb/tb_char_rom_arbiter.sv
// -----------------------------------------------------------------------------
// tb_char_rom_arbiter
// Drives two arbiter instances (RD_LATENCY 1 and 2) with identical request
// traffic and compares every output, every cycle, against a schedule-based
// reference: an accepted burst books its addresses, responses and busy
// window into per-cycle tables, which are then looked up as cycles pass.
// -----------------------------------------------------------------------------
module tb_char_rom_arbiter;

   typedef struct packed {
      logic [9:0] addr;
      logic [3:0] len;
   } req_t;

   typedef struct packed {
      logic       owner;
      logic       last;
      logic [9:0] addr;
   } exp_rsp_t;

   logic        clk;
   logic        rst;
   logic        v0, v1;
   logic [9:0]  a0, a1;
   logic [3:0]  l0, l1;
   logic [31:0] romAq, romBs1, romBq;

   int          checks;
   int          errors;
   int          cyc;
   int          freeCyc;
   logic        lastGrant;
   logic        checking;
   logic        eR0, eR1;
   logic [9:0]  holdAddr;

   logic        seenR0, seenR1, seenBusy;
   logic        idleReached, accepted;

   req_t        q0[$];
   req_t        q1[$];

   logic [9:0]  expAddr[int];
   exp_rsp_t    rspA[int];
   exp_rsp_t    rspB[int];
   bit          busyA[int];
   bit          busyB[int];
   bit          oceB[int];

   char_rom_arbiter_if #(.ADDR_WIDTH(10), .DATA_WIDTH(32)) busA ();
   char_rom_arbiter_if #(.ADDR_WIDTH(10), .DATA_WIDTH(32)) busB ();

   char_rom_arbiter #(
      .ADDR_WIDTH (10),
      .DATA_WIDTH (32),
      .RD_LATENCY (1)
   ) dutA (
      .clk (clk),
      .rst (rst),
      .bus (busA)
   );

   char_rom_arbiter #(
      .ADDR_WIDTH (10),
      .DATA_WIDTH (32),
      .RD_LATENCY (2)
   ) dutB (
      .clk (clk),
      .rst (rst),
      .bus (busB)
   );

   // Both instances see exactly the same requester traffic.
   assign busA.req0_valid = v0;
   assign busA.req0_addr  = a0;
   assign busA.req0_len   = l0;
   assign busA.req1_valid = v1;
   assign busA.req1_addr  = a1;
   assign busA.req1_len   = l1;
   assign busB.req0_valid = v0;
   assign busB.req0_addr  = a0;
   assign busB.req0_len   = l0;
   assign busB.req1_valid = v1;
   assign busB.req1_addr  = a1;
   assign busB.req1_len   = l1;
   assign busA.rom_rd_data = romAq;
   assign busB.rom_rd_data = romBq;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // ROM contents: a distinctive word derived from the address.
   function automatic logic [31:0] romWord(input logic [9:0] a);
      return {a, 6'h2A, ~a, 6'h15};
   endfunction

   // Synchronous ROM models: one plain registered read, one with an extra
   // output register gated by the oce input.
   always @(posedge clk) begin
      romAq  <= romWord(busA.rom_addr);
      romBs1 <= romWord(busB.rom_addr);
      if (busB.rom_rd_oce) begin
         romBq <= romBs1;
      end
   end

   // Single comparison point: counts the check and reports any difference.
   task automatic compare(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Compares one instance's outputs with the expectations for this cycle.
   task automatic checkOutput(input int lat,
                              input logic obsR0, input logic obsR1,
                              input logic [9:0] obsAddr, input logic obsOce,
                              input logic obsV0, input logic obsL0, input logic [31:0] obsD0,
                              input logic obsV1, input logic obsL1, input logic [31:0] obsD1,
                              input logic obsBusy);
      exp_rsp_t   er;
      logic       ev, eBusy, eOce;
      logic [9:0] eAddr;
      string      p;
      er = '0;
      p  = (lat == 1) ? "L1" : "L2";
      if (lat == 1) begin
         ev    = rspA.exists(cyc);
         if (ev) er = rspA[cyc];
         eBusy = busyA.exists(cyc);
         eOce  = 1'b0;
      end else begin
         ev    = rspB.exists(cyc);
         if (ev) er = rspB[cyc];
         eBusy = busyB.exists(cyc);
         eOce  = oceB.exists(cyc);
      end
      eAddr = expAddr.exists(cyc) ? expAddr[cyc] : holdAddr;
      compare({p, ".req0_ready"}, 32'(obsR0), 32'(eR0));
      compare({p, ".req1_ready"}, 32'(obsR1), 32'(eR1));
      compare({p, ".rom_addr"}, 32'(obsAddr), 32'(eAddr));
      compare({p, ".rom_rd_oce"}, 32'(obsOce), 32'(eOce));
      compare({p, ".rsp0_valid"}, 32'(obsV0), 32'(ev && !er.owner));
      compare({p, ".rsp0_last"}, 32'(obsL0), 32'(ev && !er.owner && er.last));
      compare({p, ".rsp0_data"}, obsD0, (ev && !er.owner) ? romWord(er.addr) : 32'd0);
      compare({p, ".rsp1_valid"}, 32'(obsV1), 32'(ev && er.owner));
      compare({p, ".rsp1_last"}, 32'(obsL1), 32'(ev && er.owner && er.last));
      compare({p, ".rsp1_data"}, obsD1, (ev && er.owner) ? romWord(er.addr) : 32'd0);
      compare({p, ".busy"}, 32'(obsBusy), 32'(eBusy));
   endtask

   // Reference model and checker. When the arbiter is free and someone is
   // requesting, it picks the winner (alternating under contention, starting
   // with req0) and books every beat of the burst into the per-cycle tables.
   // Reset wipes all bookings beyond the current cycle.
   always @(negedge clk) begin : model
      logic       g;
      int         n;
      logic [9:0] startA, beat;
      exp_rsp_t   er;
      if (checking) begin
         cyc++;
         eR0 = 1'b0;
         eR1 = 1'b0;
         if (!rst && cyc >= freeCyc && (v0 || v1)) begin
            if (v0 && v1) g = (lastGrant == 1'b0);
            else          g = v1;
            startA = g ? a1 : a0;
            n      = int'(g ? l1 : l0);
            if (g) eR1 = 1'b1;
            else   eR0 = 1'b1;
            for (int i = 0; i <= n; i++) begin
               beat     = startA + 10'(i);
               er.owner = g;
               er.last  = (i == n);
               er.addr  = beat;
               expAddr[cyc+1+i] = beat;
               rspA[cyc+2+i]    = er;
               rspB[cyc+3+i]    = er;
               oceB[cyc+2+i]    = 1'b1;
            end
            for (int k = cyc + 1; k <= cyc + 2 + n; k++) busyA[k] = 1'b1;
            for (int k = cyc + 1; k <= cyc + 3 + n; k++) busyB[k] = 1'b1;
            freeCyc   = cyc + n + 2;
            lastGrant = g;
         end
         checkOutput(1, busA.req0_ready, busA.req1_ready, busA.rom_addr, busA.rom_rd_oce,
                     busA.rsp0_valid, busA.rsp0_last, busA.rsp0_data,
                     busA.rsp1_valid, busA.rsp1_last, busA.rsp1_data, busA.busy);
         checkOutput(2, busB.req0_ready, busB.req1_ready, busB.rom_addr, busB.rom_rd_oce,
                     busB.rsp0_valid, busB.rsp0_last, busB.rsp0_data,
                     busB.rsp1_valid, busB.rsp1_last, busB.rsp1_data, busB.busy);
         if (expAddr.exists(cyc)) holdAddr = expAddr[cyc];
         if (rst) begin
            for (int k = cyc + 1; k <= cyc + 40; k++) begin
               if (expAddr.exists(k)) expAddr.delete(k);
               if (rspA.exists(k))    rspA.delete(k);
               if (rspB.exists(k))    rspB.delete(k);
               if (busyA.exists(k))   busyA.delete(k);
               if (busyB.exists(k))   busyB.delete(k);
               if (oceB.exists(k))    oceB.delete(k);
            end
            holdAddr  = 10'd0;
            freeCyc   = cyc + 1;
            lastGrant = 1'b1;
         end
      end
   end

   // Queues a burst request for one requester.
   task automatic applyStimulus(input int who, input logic [9:0] addr, input logic [3:0] len);
      req_t r;
      r.addr = addr;
      r.len  = len;
      if (who == 0) q0.push_back(r);
      else          q1.push_back(r);
   endtask

   // Behaves as the two requesters: holds a request until its ready is seen,
   // then presents the next queued one.
   task automatic runCycles(input int n);
      req_t r;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         seenR0   = busA.req0_ready;
         seenR1   = busA.req1_ready;
         seenBusy = busA.busy || busB.busy;
         @(posedge clk);
         #2;
         if (seenR0) v0 = 1'b0;
         if (seenR1) v1 = 1'b0;
         if (!v0 && q0.size() > 0) begin
            r  = q0.pop_front();
            v0 = 1'b1;
            a0 = r.addr;
            l0 = r.len;
         end
         if (!v1 && q1.size() > 0) begin
            r  = q1.pop_front();
            v1 = 1'b1;
            a1 = r.addr;
            l1 = r.len;
         end
      end
   endtask

   task automatic runUntilIdle(input int budget);
      int n;
      n = 0;
      idleReached = 1'b0;
      while (n < budget && !idleReached) begin
         runCycles(1);
         n++;
         idleReached = (q0.size() == 0) && (q1.size() == 0) && !v0 && !v1 &&
                       !seenBusy && !seenR0 && !seenR1;
      end
      checks++;
      assert (idleReached === 1'b1) else begin
         errors++;
         $error("[TB] FAIL idle_timeout observed=%0d expected=1", idleReached);
      end
   endtask

   task automatic waitAccept0(input int budget);
      int n;
      n = 0;
      accepted = 1'b0;
      while (n < budget && !accepted) begin
         runCycles(1);
         n++;
         accepted = seenR0;
      end
      checks++;
      assert (accepted === 1'b1) else begin
         errors++;
         $error("[TB] FAIL accept_timeout observed=%0d expected=1", accepted);
      end
   endtask

   // Hard stop in case something wedges outside the bounded waits.
   initial begin
      #800000;
      $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      checks    = 0;
      errors    = 0;
      cyc       = 0;
      freeCyc   = 0;
      lastGrant = 1'b1;
      holdAddr  = 10'd0;
      checking  = 1'b0;
      eR0 = 1'b0;  eR1 = 1'b0;
      seenR0 = 1'b0;  seenR1 = 1'b0;  seenBusy = 1'b0;
      v0 = 1'b0;  v1 = 1'b0;
      a0 = 10'd0; a1 = 10'd0;
      l0 = 4'd0;  l1 = 4'd0;
      rst = 1'b1;

      @(posedge clk);
      #2;
      checking = 1'b1;
      runCycles(2);
      rst = 1'b0;

      $display("[TB] single requester burst");
      applyStimulus(0, 10'h041, 4'd15);
      runUntilIdle(200);

      $display("[TB] contention after reset");
      rst = 1'b1;
      runCycles(2);
      rst = 1'b0;
      applyStimulus(0, 10'h100, 4'd3);
      applyStimulus(0, 10'h180, 4'd2);
      applyStimulus(1, 10'h200, 4'd4);
      runUntilIdle(200);
      applyStimulus(0, 10'h010, 4'd1);
      applyStimulus(1, 10'h020, 4'd1);
      runUntilIdle(200);

      $display("[TB] address wrap");
      applyStimulus(1, 10'h3FE, 4'd3);
      runUntilIdle(200);

      $display("[TB] withdrawn request");
      applyStimulus(0, 10'($urandom_range(0, 1023)), 4'd10);
      waitAccept0(50);
      runCycles(2);
      v1 = 1'b1;
      a1 = 10'($urandom_range(0, 1023));
      l1 = 4'($urandom_range(0, 15));
      runCycles(3);
      v1 = 1'b0;
      runUntilIdle(200);

      $display("[TB] reset mid-burst");
      applyStimulus(0, 10'($urandom_range(0, 1023)), 4'd15);
      waitAccept0(50);
      runCycles(4);
      rst = 1'b1;
      runCycles(1);
      rst = 1'b0;
      runCycles(4);
      applyStimulus(0, 10'($urandom_range(0, 1023)), 4'($urandom_range(0, 15)));
      runUntilIdle(200);

      $display("[TB] random traffic");
      for (int t = 0; t < 30; t++) begin
         case ($urandom_range(0, 2))
            0: applyStimulus(0, 10'($urandom_range(0, 1023)), 4'($urandom_range(0, 15)));
            1: applyStimulus(1, 10'($urandom_range(0, 1023)), 4'($urandom_range(0, 15)));
            default: begin
               applyStimulus(0, 10'($urandom_range(0, 1023)), 4'($urandom_range(0, 15)));
               applyStimulus(1, 10'($urandom_range(0, 1023)), 4'($urandom_range(0, 15)));
            end
         endcase
         runCycles($urandom_range(0, 12));
      end
      runUntilIdle(3000);

      runCycles(3);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
